// File: rtl/boot_pkg.sv
// Shared types and constants for the BRAM boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES    = 4;

endpackage

// File: rtl/boot_word_packer.sv
// Packs payload bytes into little-endian 32-bit words and emits one registered
// masked write when lane 3 fills or the last payload byte arrives.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic [1:0]  start_lane,
    input  logic        valid,
    input  logic        last,
    input  logic [7:0]  byte_in,
    output logic [3:0]  we,
    output logic [31:0] di,
    output logic        flush
);

    logic [1:0]  ptr;
    logic [3:0]  mask, mask_nx;
    logic [31:0] wbuf, wbuf_nx;

    always_comb begin
        mask_nx = mask | (4'b0001 << ptr);
        wbuf_nx = wbuf;
        wbuf_nx[{ptr, 3'b000} +: 8] = byte_in;
        flush   = valid && (ptr == 2'd3 || last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            mask <= '0;
            wbuf <= '0;
            we   <= '0;
            di   <= '0;
        end else begin
            we <= '0;
            if (init) begin
                ptr  <= start_lane;
                mask <= '0;
                wbuf <= '0;
            end else if (valid) begin
                ptr <= ptr + 2'd1;
                if (flush) begin
                    // The same-cycle byte is in wbuf_nx, so the word starts fresh next cycle.
                    we   <= mask_nx;
                    di   <= wbuf_nx;
                    mask <= '0;
                    wbuf <= '0;
                end else begin
                    mask <= mask_nx;
                    wbuf <= wbuf_nx;
                end
            end
        end
    end

endmodule

// File: rtl/bram_boot_loader.sv
// UART-framed boot loader: SYNC, LE start address, LE length, payload, optional
// checksum (enable with BOOT_CHECKSUM_EN). Holds the core in reset until loaded.
module bram_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] MEM_BYTES   = 32'h0025_0000,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst_n
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t ST_POST = ST_CSUM;
    logic [7:0] csum;
`else
    localparam boot_state_t ST_POST = ST_DONE;
`endif

    boot_state_t state, state_nx;
    logic [1:0]  hdr_cnt;
    logic [31:0] addr_sr;
    logic [23:0] len_sr;
    logic [31:0] rem;
    logic [29:0] cur_word;
    logic [31:0] tmo_cnt;
    logic [31:0] len_full;
    logic [32:0] end_addr;
    logic        hdr_last, range_bad, byte_take, pk_init, pk_flush, tmo_hit;

    assign busy      = (state == ST_ADDR) || (state == ST_LEN) ||
                       (state == ST_DATA) || (state == ST_CSUM);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign cpu_rst_n = done;

    assign hdr_last  = (hdr_cnt == 2'(HDR_BYTES - 1));
    assign len_full  = {rx_data, len_sr};
    // 33-bit sum so a wrap past 2^32 still reads as out of range.
    assign end_addr  = {1'b0, addr_sr} + {1'b0, len_full};
    assign range_bad = end_addr > {1'b0, MEM_BYTES};
    assign byte_take = (state == ST_DATA) && rx_valid && (rem != '0);
    assign pk_init   = (state == ST_LEN) && rx_valid && hdr_last;
    assign tmo_hit   = (TIMEOUT_CYC != 0) && busy && !rx_valid &&
                       (tmo_cnt == TIMEOUT_CYC - 1);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_nx = ST_ADDR;
            ST_ADDR: if (rx_valid && hdr_last) state_nx = ST_LEN;
            ST_LEN: begin
                if (rx_valid && hdr_last) begin
                    if (len_full == '0)  state_nx = ST_POST;
                    else if (range_bad)  state_nx = ST_ERR;
                    else                 state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
`ifdef BOOT_CHECKSUM_EN
                if (byte_take && rem == 32'd1) state_nx = ST_CSUM;
`else
                // One cycle after the last byte so done trails the final write pulse.
                if (rem == '0) state_nx = ST_DONE;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: if (rx_valid) state_nx = (rx_data == csum) ? ST_DONE : ST_ERR;
`endif
            ST_ERR:  if (rx_valid && rx_data == SYNC_BYTE) state_nx = ST_ADDR;
            default: state_nx = state;
        endcase
        if (tmo_hit) state_nx = ST_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hdr_cnt  <= '0;
            addr_sr  <= '0;
            len_sr   <= '0;
            rem      <= '0;
            cur_word <= '0;
            tmo_cnt  <= '0;
            mem_addr <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state <= state_nx;
            if (!busy)
                hdr_cnt <= '0;
            else if (rx_valid && (state == ST_ADDR || state == ST_LEN))
                hdr_cnt <= hdr_cnt + 2'd1;
            if (state == ST_ADDR && rx_valid) addr_sr <= {rx_data, addr_sr[31:8]};
            if (state == ST_LEN && rx_valid)  len_sr  <= len_full[31:8];
            if (pk_init) begin
                rem      <= len_full;
                cur_word <= addr_sr[31:2];
            end else if (byte_take) begin
                rem <= rem - 32'd1;
            end
            if (pk_flush) begin
                mem_addr <= {cur_word, 2'b00};
                cur_word <= cur_word + 30'd1;
            end
            tmo_cnt <= (!busy || rx_valid) ? '0 : tmo_cnt + 32'd1;
`ifdef BOOT_CHECKSUM_EN
            if (!busy)          csum <= '0;
            else if (byte_take) csum <= csum + rx_data;
`endif
        end
    end

    boot_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (pk_init),
        .start_lane (addr_sr[1:0]),
        .valid      (byte_take),
        .last       (rem == 32'd1),
        .byte_in    (rx_data),
        .we         (mem_we),
        .di         (mem_di),
        .flush      (pk_flush)
    );

endmodule

// File: tb/tb_bram_boot_loader.sv
// Directed bench for bram_boot_loader: expected BRAM writes go into a scoreboard
// queue; a monitor pops and compares every write pulse. Honours BOOT_CHECKSUM_EN.
module tb_bram_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n, rx_valid;
    logic [7:0]  rx_data;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_di;
    logic        busy, done, err, cpu_rst_n;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    bram_boot_loader #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_di    (mem_di),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_t w;
        w.a = a; w.m = m; w.d = d;
        sb.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_hdr(input logic with_sync, input logic [31:0] addr,
                            input logic [31:0] len, input int gap);
        if (with_sync) send_byte(8'hA5, gap);
        send_word(addr, gap);
        send_word(len, gap);
    endtask

    task automatic send_frame(input logic with_sync, input logic [31:0] addr,
                              input logic [7:0] pl[$], input int gap);
        send_hdr(with_sync, addr, 32'(pl.size()), gap);
        foreach (pl[i]) send_byte(pl[i], gap);
`ifdef BOOT_CHECKSUM_EN
        begin
            logic [7:0] sum;
            sum = '0;
            foreach (pl[i]) sum = sum + pl[i];
            send_byte(sum, gap);
        end
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_loaded(input string nm);
        repeat (3) @(negedge clk);
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd1);
        chk({nm, "_err"}, 64'(err), 64'd0);
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Write monitor: every nonzero mem_we must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_we != 4'h0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_we, 28'h0}, 64'h0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.a));
                    chk("wr_mask", 64'(mem_we), 64'(e.m));
                    chk("wr_data", 64'(mem_di), 64'(e.d));
                    chk("done_low_during_write", 64'(done), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [7:0] pl[$];
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {mem_we, mem_addr, mem_di, busy, done, err, cpu_rst_n}, 64'h0);

        // Aligned image, one idle cycle between bytes
        push(32'h100, 4'hF, 32'h14131211);
        push(32'h104, 4'hF, 32'h18171615);
        pl = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        send_frame(1'b1, 32'h100, pl, 1);
        chk_loaded("aligned");
        send_byte(8'hA5, 1);
        chk("done_ignores_sync", {busy, done}, 64'b01);

        // Unaligned start, partial words; 15-cycle gaps stay below the timeout
        do_reset();
        push(32'h100, 4'b1100, 32'hBBAA0000);
        push(32'h104, 4'b0111, 32'h00EEDDCC);
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_frame(1'b1, 32'h102, pl, 15);
        chk_loaded("unaligned");

        // Range failure, then recovery with an image ending exactly at MEM_BYTES
        do_reset();
        send_hdr(1'b1, 32'h0024FFFC, 32'd8, 0);
        repeat (2) @(negedge clk);
        chk("range_err", {err, busy, cpu_rst_n}, 64'b100);
        send_byte(8'h11, 1);
        chk("err_ignores_byte", 64'(err), 64'd1);
        send_byte(8'hA5, 0);
        chk("err_sync_clears", {err, busy}, 64'b01);
        push(32'h0024FFFC, 4'hF, 32'h04030201);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b0, 32'h0024FFFC, pl, 0);
        chk_loaded("range_edge");

        // 32-bit wrap of start+len must be rejected
        do_reset();
        send_hdr(1'b1, 32'hFFFFFFF0, 32'h20, 0);
        repeat (2) @(negedge clk);
        chk("carry_err", 64'(err), 64'd1);

        // Back-to-back strobes, 12 bytes
        do_reset();
        push(32'h400, 4'hF, 32'h23222120);
        push(32'h404, 4'hF, 32'h27262524);
        push(32'h408, 4'hF, 32'h2B2A2928);
        pl = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
               8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B};
        send_frame(1'b1, 32'h400, pl, 0);
        chk_loaded("b2b");

        // Zero-length image
        do_reset();
        pl = {};
        send_frame(1'b1, 32'h100, pl, 0);
        chk_loaded("len0");

        // Timeout mid-payload discards the pending partial word
        do_reset();
        push(32'h100, 4'hF, 32'h04030201);
        send_hdr(1'b1, 32'h100, 32'd8, 0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        send_byte(8'h06, 16);
        chk("timeout_err", {err, busy, done}, 64'b100);
        repeat (4) @(negedge clk);
        chk("timeout_sb_empty", 64'(sb.size()), 64'd0);

        // Async reset while a write pulse is on the port
        do_reset();
        push(32'h100, 4'hF, 32'h04030201);
        send_hdr(1'b1, 32'h100, 32'd8, 0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_outputs", {mem_we, mem_addr, mem_di, busy, done, err, cpu_rst_n}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h05, 2);
        chk("post_rst_idle", {busy, err, mem_we}, 64'h0);
        chk("rst_sb_empty", 64'(sb.size()), 64'd0);

`ifdef BOOT_CHECKSUM_EN
        // Correct and wrong checksum
        do_reset();
        push(32'h100, 4'b0111, 32'h00030201);
        send_hdr(1'b1, 32'h100, 32'd3, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
        send_byte(8'h06, 0);
        chk_loaded("csum_ok");
        do_reset();
        push(32'h100, 4'b0111, 32'h00030201);
        send_hdr(1'b1, 32'h100, 32'd3, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
        send_byte(8'h07, 0);
        repeat (3) @(negedge clk);
        chk("csum_bad", {err, done, cpu_rst_n}, 64'b100);
        chk("csum_bad_sb_empty", 64'(sb.size()), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
